input_conditioner: RTL and testbench

//  Per-bit conditioning of asynchronous mech inputs (sensors, motor phases, strobes) into the clk domain.

---
 rtl/input_conditioner.sv | 118 +++++++++++
 tb/tb_input_conditioner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: brings asynchronous mechanical inputs (sensors, motor
// phases, strobes) into the clk domain, one independent channel per bit.
// Each channel goes through an STAGES-deep synchroniser, then a debounce
// filter that only accepts a new level after it has held for FILTER_CYCLES
// cycles. A registered one-cycle rise/fall pulse marks each accepted change.
// Latency: a clean step on d_in reaches d_out after STAGES+FILTER_CYCLES
// rising edges of clk.
//
// Ports:
//   clk     rising-edge clock for all state
//   reset   asynchronous, active-high; loads RESET_VALUE and clears the pulses
//   d_in    raw asynchronous inputs
//   d_sync  last synchroniser stage (unfiltered, registered)
//   d_out   debounced level (registered)
//   rise    one-cycle pulse, asserted in the cycle d_out[i] changes 0->1
//   fall    one-cycle pulse, asserted in the cycle d_out[i] changes 1->0
module input_conditioner #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_sync,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject illegal configurations when the design is elaborated.
  if (WIDTH < 1) begin : g_bad_width
    $error("input_conditioner: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("input_conditioner: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("input_conditioner: FILTER_CYCLES must be >= 1");
  end

  localparam int             CW      = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CYCLES - 1);

  // Synchroniser chain. The reset value is loaded into every stage, so
  // d_sync agrees with d_out immediately after reset.
  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= d_in;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign d_sync = sync_q[STAGES-1];

  // Debounce filter, one per channel. A channel is STABLE when d_sync equals
  // d_out and PENDING when they differ. The counter records how many
  // consecutive cycles the channel has been PENDING.
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Clearing the counter in STABLE means that an interrupted pending
      // run starts again from zero the next time the input changes.
      cnt_d[i] = '0;
      if (d_sync[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // The new level has held long enough: accept it. The counter goes
          // back to zero, so it never passes CNT_MAX.
          out_d[i]  = d_sync[i];
          rise_d[i] = d_sync[i];
          fall_d[i] = ~d_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign d_out = out_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner. It uses three instances:
//   A: WIDTH=4, STAGES=2, FILTER_CYCLES=4, RESET_VALUE=0 (table-driven)
//   B: same depths, RESET_VALUE=4'b1010 (asynchronous reset in mid-filter)
//   C: WIDTH=1, STAGES=3, FILTER_CYCLES=1 (no filtering, toggling input)
module tb_input_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [3:0] din_a, din_b;
  logic [0:0] din_c;
  logic [3:0] sync_a, out_a, rise_a, fall_a;
  logic [3:0] sync_b, out_b, rise_b, fall_b;
  logic [0:0] sync_c, out_c, rise_c, fall_c;

  input_conditioner #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(4'b0000)) u_a (
    .clk(clk), .reset(rst_a), .d_in(din_a),
    .d_sync(sync_a), .d_out(out_a), .rise(rise_a), .fall(fall_a));

  input_conditioner #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(4'b1010)) u_b (
    .clk(clk), .reset(rst_b), .d_in(din_b),
    .d_sync(sync_b), .d_out(out_b), .rise(rise_b), .fall(fall_b));

  input_conditioner #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(1'b0)) u_c (
    .clk(clk), .reset(rst_c), .d_in(din_c),
    .d_sync(sync_c), .d_out(out_c), .rise(rise_c), .fall(fall_c));

  // One table row: the input applied before an edge, and the outputs
  // expected just after that edge.
  typedef struct packed {
    logic [3:0] din;
    logic [3:0] sync;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic add_vec(input logic [3:0] di, input logic [3:0] s, input logic [3:0] o,
                         input logic [3:0] r, input logic [3:0] f);
    vec_t v;
    v.din = di; v.sync = s; v.dout = o; v.rise = r; v.fall = f;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Stop a hung run rather than wait forever.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:0] pat [24];
    logic       exp_o, prev_o, exp_s;

    // Test 1: d_in[0] steps 0->1 and is held.
    add_vec(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h1, 4'h1, 4'h0);   // edge 6: d_out and rise
    add_vec(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);   // edge 7: the pulse ends
    // Test 2: a 3-cycle low glitch is rejected.
    add_vec(4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
    add_vec(4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add_vec(4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add_vec(4'h1, 4'h0, 4'h1, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    add_vec(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    // Move to d_out=4'b0100: bit 0 falls and bit 2 rises together.
    add_vec(4'h4, 4'h1, 4'h1, 4'h0, 4'h0);
    add_vec(4'h4, 4'h4, 4'h1, 4'h0, 4'h0);
    add_vec(4'h4, 4'h4, 4'h1, 4'h0, 4'h0);
    add_vec(4'h4, 4'h4, 4'h1, 4'h0, 4'h0);
    add_vec(4'h4, 4'h4, 4'h1, 4'h0, 4'h0);
    add_vec(4'h4, 4'h4, 4'h4, 4'h4, 4'h1);
    // Test 3: d_in[1] rises while d_in[2] falls in the same cycle.
    add_vec(4'h2, 4'h4, 4'h4, 4'h0, 4'h0);
    add_vec(4'h2, 4'h2, 4'h4, 4'h0, 4'h0);
    add_vec(4'h2, 4'h2, 4'h4, 4'h0, 4'h0);
    add_vec(4'h2, 4'h2, 4'h4, 4'h0, 4'h0);
    add_vec(4'h2, 4'h2, 4'h4, 4'h0, 4'h0);
    add_vec(4'h2, 4'h2, 4'h2, 4'h2, 4'h4);
    add_vec(4'h2, 4'h2, 4'h2, 4'h0, 4'h0);
    // Test 4: d_sync[0] differs for 3 cycles, agrees for 1, then differs for 4.
    add_vec(4'h3, 4'h2, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h2, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h2, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h2, 4'h0, 4'h0);
    add_vec(4'h3, 4'h3, 4'h3, 4'h1, 4'h0);
    add_vec(4'h3, 4'h3, 4'h3, 4'h0, 4'h0);

    // Reset all instances, then check the reset values before any clock edge.
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    din_a = 4'h0; din_b = 4'b1010; din_c = 1'b0;
    #3;
    check("reset.a.d_sync", sync_a, 4'h0);
    check("reset.a.d_out",  out_a,  4'h0);
    check("reset.a.rise",   rise_a, 4'h0);
    check("reset.a.fall",   fall_a, 4'h0);
    check("reset.b.d_sync", sync_b, 4'b1010);
    check("reset.b.d_out",  out_b,  4'b1010);
    check("reset.c.d_out",  {3'b0, out_c}, 4'h0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Tests 1 to 4 on instance A, driven from the table.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      din_a = tbl[i].din;
      @(posedge clk);
      #1;
      check($sformatf("row%0d.d_sync", i + 1), sync_a, tbl[i].sync);
      check($sformatf("row%0d.d_out",  i + 1), out_a,  tbl[i].dout);
      check($sformatf("row%0d.rise",   i + 1), rise_a, tbl[i].rise);
      check($sformatf("row%0d.fall",   i + 1), fall_a, tbl[i].fall);
    end

    // Test 5: instance B is reset while a change is pending.
    @(negedge clk);
    din_b = 4'b0000;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) check("t5.pre.d_sync", sync_b, 4'b0000);
    end
    check("t5.pre.d_out", out_b, 4'b1010);
    #2;
    rst_b = 1'b1;
    #1;
    check("t5.async.d_sync", sync_b, 4'b1010);
    check("t5.async.d_out",  out_b,  4'b1010);
    check("t5.async.rise",   rise_b, 4'b0000);
    check("t5.async.fall",   fall_b, 4'b0000);
    @(negedge clk);
    rst_b = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) check("t5.e1.d_sync", sync_b, 4'b1010);
      if (e == 2) check("t5.e2.d_sync", sync_b, 4'b0000);
      if (e == 5) check("t5.e5.d_out",  out_b,  4'b1010);
      if (e == 5) check("t5.e5.fall",   fall_b, 4'b0000);
      if (e == 6) check("t5.e6.d_out",  out_b,  4'b0000);
      if (e == 6) check("t5.e6.fall",   fall_b, 4'b1010);
      if (e == 6) check("t5.e6.rise",   rise_b, 4'b0000);
      if (e == 7) check("t5.e7.fall",   fall_b, 4'b0000);
    end

    // Test 6: instance C with no filtering. A step, then toggling on every
    // cycle. The input applied before edge n shows on d_sync after edge n+2
    // and on d_out after edge n+3.
    for (int k = 0; k < 24; k++) pat[k] = 1'b0;
    for (int k = 0; k < 5; k++)  pat[k] = 1'b1;
    for (int k = 5; k < 12; k++) pat[k] = (k % 2 == 0) ? 1'b1 : 1'b0;
    prev_o = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      din_c = pat[n-1];
      @(posedge clk);
      #1;
      exp_s = (n >= 3) ? pat[n-3][0] : 1'b0;
      exp_o = (n >= 4) ? pat[n-4][0] : 1'b0;
      check($sformatf("t6.e%0d.d_sync", n), {3'b0, sync_c}, {3'b0, exp_s});
      check($sformatf("t6.e%0d.d_out",  n), {3'b0, out_c},  {3'b0, exp_o});
      check($sformatf("t6.e%0d.rise",   n), {3'b0, rise_c}, {3'b0, exp_o & ~prev_o});
      check($sformatf("t6.e%0d.fall",   n), {3'b0, fall_c}, {3'b0, ~exp_o & prev_o});
      prev_o = exp_o;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
